// File: rtl/fu_issue_scheduler.sv
// Issue/completion scheduler: grants registered one cycle after ready, CDB result LAT cycles after grant; DONE units losing the CDB hold (no loss).
// Build option SCHED_RR_EN: rotating per-station search pointer instead of lowest-index-first priority.
module fu_issue_scheduler #(
    parameter int NUM_RS1 = 4,
    parameter int NUM_RS2 = 4,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [NUM_RS1-1:0] rs1_ready,
    input  logic [NUM_RS1-1:0] rs1_free,
    input  logic [NUM_RS2-1:0] rs2_ready,
    input  logic [NUM_RS2-1:0] rs2_free,
    output logic [NUM_RS1-1:0] rs1_grant0,
    output logic [NUM_RS1-1:0] rs1_grant1,
    output logic [NUM_RS2-1:0] rs2_grant,
    output logic [2:0]         fu_busy,
    output logic               cdb_valid,
    output logic [1:0]         cdb_fu,
    output logic [2:0]         cdb_rs_idx
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} unit_state_t;

    localparam logic [3:0] ADD_LOAD = 4'(ADD_LAT - 1);
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
    localparam int IW1 = $clog2(NUM_RS1);
    localparam int IW2 = $clog2(NUM_RS2);

    unit_state_t        state [3];
    logic [3:0]         cnt [3];
    logic [2:0]         idx [3];
    logic [NUM_RS1-1:0] issued1;
    logic [NUM_RS2-1:0] issued2;
    logic [2:0]         base1, base2;

    logic [NUM_RS1-1:0] elig1;
    logic [NUM_RS2-1:0] elig2;
    logic [3:0]         k1, k2;
    logic [2:0]         cand_a, cand_b, cand_m;
    logic               has_a, has_b, has_m;

    always_comb begin
        elig1  = rs1_ready & ~issued1 & ~rs1_free;
        elig2  = rs2_ready & ~issued2 & ~rs2_free;
        cand_a = '0;
        cand_b = '0;
        cand_m = '0;
        has_a  = 1'b0;
        has_b  = 1'b0;
        has_m  = 1'b0;
        k1     = '0;
        k2     = '0;
        // Walk each station starting at its base index, wrapping modulo its size.
        for (int i = 0; i < NUM_RS1; i++) begin
            k1 = {1'b0, base1} + 4'(i);
            if (k1 >= 4'(NUM_RS1)) k1 = k1 - 4'(NUM_RS1);
            if (elig1[k1[IW1-1:0]]) begin
                if (!has_a) begin
                    has_a  = 1'b1;
                    cand_a = k1[2:0];
                end else if (!has_b) begin
                    has_b  = 1'b1;
                    cand_b = k1[2:0];
                end
            end
        end
        for (int i = 0; i < NUM_RS2; i++) begin
            k2 = {1'b0, base2} + 4'(i);
            if (k2 >= 4'(NUM_RS2)) k2 = k2 - 4'(NUM_RS2);
            if (elig2[k2[IW2-1:0]] && !has_m) begin
                has_m  = 1'b1;
                cand_m = k2[2:0];
            end
        end
    end

    logic [2:0]         idle, done, go, win;
    logic [2:0]         go_idx [3];
    logic [NUM_RS1-1:0] oh0, oh1;
    logic [NUM_RS2-1:0] oh2;

    always_comb begin
        for (int u = 0; u < 3; u++) begin
            idle[u] = (state[u] == IDLE);
            done[u] = (state[u] == DONE);
        end
        // A busy add0 hands its candidate to add1.
        go[0]     = idle[0] & has_a;
        go[1]     = idle[1] & (idle[0] ? has_b : has_a);
        go[2]     = idle[2] & has_m;
        go_idx[0] = cand_a;
        go_idx[1] = idle[0] ? cand_b : cand_a;
        go_idx[2] = cand_m;
        win[2]    = done[2];
        win[0]    = done[0] & ~done[2];
        win[1]    = done[1] & ~done[0] & ~done[2];
        oh0 = '0;
        oh1 = '0;
        oh2 = '0;
        if (go[0]) oh0 = {{(NUM_RS1-1){1'b0}}, 1'b1} << go_idx[0];
        if (go[1]) oh1 = {{(NUM_RS1-1){1'b0}}, 1'b1} << go_idx[1];
        if (go[2]) oh2 = {{(NUM_RS2-1){1'b0}}, 1'b1} << go_idx[2];
    end

    assign fu_busy = ~idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 3; u++) begin
                state[u] <= IDLE;
                cnt[u]   <= '0;
                idx[u]   <= '0;
            end
            issued1    <= '0;
            issued2    <= '0;
            rs1_grant0 <= '0;
            rs1_grant1 <= '0;
            rs2_grant  <= '0;
            cdb_valid  <= 1'b0;
            cdb_fu     <= '0;
            cdb_rs_idx <= '0;
        end else if (flush) begin
            for (int u = 0; u < 3; u++) begin
                state[u] <= IDLE;
                cnt[u]   <= '0;
                idx[u]   <= '0;
            end
            issued1    <= '0;
            issued2    <= '0;
            rs1_grant0 <= '0;
            rs1_grant1 <= '0;
            rs2_grant  <= '0;
            cdb_valid  <= 1'b0;
            cdb_fu     <= '0;
            cdb_rs_idx <= '0;
        end else begin
            rs1_grant0 <= oh0;
            rs1_grant1 <= oh1;
            rs2_grant  <= oh2;
            issued1    <= (issued1 & ~rs1_free) | oh0 | oh1;
            issued2    <= (issued2 & ~rs2_free) | oh2;
            cdb_valid  <= |win;
            cdb_fu     <= win[2] ? 2'd2 : (win[1] ? 2'd1 : 2'd0);
            cdb_rs_idx <= win[2] ? idx[2] : (win[0] ? idx[0] : (win[1] ? idx[1] : 3'd0));
            for (int u = 0; u < 3; u++) begin
                case (state[u])
                    IDLE: if (go[u]) begin
                        idx[u] <= go_idx[u];
                        cnt[u] <= (u == 2) ? MUL_LOAD : ADD_LOAD;
                        // Single-cycle units complete in their grant cycle.
                        if (((u == 2) ? MUL_LOAD : ADD_LOAD) == 4'd0) state[u] <= DONE;
                        else                                           state[u] <= EXEC;
                    end
                    EXEC: begin
                        cnt[u] <= cnt[u] - 4'd1;
                        if (cnt[u] == 4'd1) state[u] <= DONE;
                    end
                    DONE: if (win[u]) state[u] <= IDLE;
                    default: state[u] <= IDLE;
                endcase
            end
        end
    end

`ifdef SCHED_RR_EN
    logic [2:0] ptr1, ptr2, hi1;

    function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int n);
        logic [3:0] s;
        s = {1'b0, v} + 4'd1;
        return (s >= 4'(n)) ? 3'd0 : s[2:0];
    endfunction

    always_comb begin
        hi1 = go_idx[0];
        if (go[1] && (!go[0] || go_idx[1] > go_idx[0])) hi1 = go_idx[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr1 <= '0;
            ptr2 <= '0;
        end else if (flush) begin
            ptr1 <= '0;
            ptr2 <= '0;
        end else begin
            if (go[0] || go[1]) ptr1 <= wrap_inc(hi1, NUM_RS1);
            if (go[2])          ptr2 <= wrap_inc(go_idx[2], NUM_RS2);
        end
    end

    assign base1 = ptr1;
    assign base2 = ptr2;
`else
    assign base1 = 3'd0;
    assign base2 = 3'd0;
`endif
endmodule
